reg_dump_sequencer: RTL
=======================

Name: reg_dump_sequencer

Overview:
Reader-side companion to the eight-entry LC-3 general-purpose register file. On a Start pulse it walks the register-file read select from R0 to R7 and captures each 16-bit value. It then presents each value, with its index, on a valid/ready output stream. The stream feeds debug consumers such as the hex-display scroller or a memory dump writer. It owns the SR1 read select only while Busy; the datapath owns it otherwise, with the select mux outside this block.

Parameters:
NUM_REGS, 8, number of registers dumped, indices 0..NUM_REGS-1
DATA_W, 16, register data width
IDX_W, 3, index width, clog2(NUM_REGS)

Ports:
Clk  input  1  clock
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request to begin a dump; ignored while Busy
Abort  input  1  cancel an in-progress dump
SR1_Sel  output  IDX_W  register-file read select; valid only while Busy
SR1_In  input  DATA_W  register-file SR1 read data, combinational from SR1_Sel
Out_Data  output  DATA_W  captured register value
Out_Idx  output  IDX_W  register index of Out_Data
Out_Valid  output  1  Out_Data/Out_Idx valid
Out_Ready  input  1  consumer accepts the word when Out_Valid and Out_Ready are both high
Busy  output  1  high from the cycle after Start until Done
Done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: Clk; Reset is synchronous, active-high.
- Reset values: state IDLE, idx 0, SR1_Sel 0, Out_Data 0, Out_Idx 0, Out_Valid 0, Busy 0, Done 0. Reset mid-dump forces IDLE on the next edge; no Done pulse.
- States: IDLE, FETCH, PRESENT, FIN.
- IDLE: Busy 0. Start=1 -> FETCH, idx<=0.
- FETCH (one cycle): SR1_Sel=idx, Busy 1. At the edge: Out_Data<=SR1_In, Out_Idx<=idx, Out_Valid<=1, go to PRESENT.
- PRESENT: Out_Valid 1; Out_Data and Out_Idx held stable until handshake.
  - Out_Ready=1 and idx==NUM_REGS-1 -> FIN, Out_Valid<=0.
  - Out_Ready=1 otherwise -> idx<=idx+1, FETCH, Out_Valid<=0.
  - Out_Ready=0 -> stay.
- FIN (one cycle): Done=1, Busy=1 -> IDLE. Done is registered and asserted exactly during the FIN cycle.
- Latency: Start sampled at edge N -> FETCH at cycle N+1 -> first Out_Valid at cycle N+2. With Out_Ready tied high, one word every 2 cycles. A full 8-register dump takes 16 cycles from Start to the last handshake, and Done is high at cycle N+17.
- Live read, no snapshot:
  - Each value is sampled in its own FETCH cycle.
  - A register written by the datapath before its FETCH is dumped with the new value.
  - A write after its FETCH is not reflected.
- Abort: in any non-IDLE state, Abort=1 -> IDLE at the next edge with Out_Valid<=0, Busy<=0, no Done. Abort overrides Out_Ready in the same cycle; the word is not considered accepted. Abort in IDLE has no effect.
- Start while Busy is ignored. Start and Abort together in IDLE: Start wins.
- idx never wraps. FIN is entered only from the last index, and idx resets to 0 on the next Start.
- Out_Valid never drops without a handshake, except on Abort or Reset.

Decomposition:
- Shared package lc3_pkg: typedef reg_idx_t (logic [2:0]); typedef word_t (logic [15:0]); constant LC3_NUM_REGS=8; enum dump_state_t {IDLE, FETCH, PRESENT, FIN}.
- Single module. No sub-module is warranted. The FSM, index counter and output register form one block of roughly 150 lines.

Test Plan:
- Preload R0..R7 = 16'h1000..16'h1007, Out_Ready=1, pulse Start -> 8 words, Out_Idx 0..7, Out_Data 16'h1000..16'h1007, first Out_Valid 2 cycles after Start, Done single pulse 17 cycles after Start, Busy low the next cycle.
- Same preload, Out_Ready low for 5 cycles on word 3 -> Out_Data holds 16'h1003 and Out_Idx holds 3 for all 5 cycles; sequence then completes with no duplicates or drops.
- Datapath writes R5=16'hBEEF while word 2 is presented -> dumped R5 reads 16'hBEEF. Write R1=16'hDEAD after word 1 is captured -> dumped R1 keeps 16'h1001.
- Abort asserted while presenting word 4 with Out_Ready=1 -> next cycle IDLE, Out_Valid=0, Busy=0, no Done. A subsequent Start restarts at Out_Idx 0.
- Start pulsed again during a dump, then Reset asserted mid-FETCH of word 6 -> second Start has no effect. After Reset, all outputs are 0 and the state is IDLE; no Done pulse occurs.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 types: register index and data words, register count, and the
// state encoding of the register-dump sequencer.
package lc3_pkg;

    localparam int LC3_NUM_REGS = 8;

    typedef logic [2:0]  reg_idx_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        FIN     = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_sequencer.sv
// Walks the LC-3 register file R0..R7 through the SR1 read port and streams
// each captured value, tagged with its index, on a valid/ready output.
module reg_dump_sequencer
    import lc3_pkg::*;
#(
    parameter int NUM_REGS = LC3_NUM_REGS,
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    output logic [IDX_W-1:0]  SR1_Sel,
    input  logic [DATA_W-1:0] SR1_In,
    output logic [DATA_W-1:0] Out_Data,
    output logic [IDX_W-1:0]  Out_Idx,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Busy,
    output logic              Done,
    output dump_state_t       State
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dump_state_t      state;
    logic [IDX_W-1:0] idx;

    // Output stream: a word transfers on any edge where Out_Valid and
    // Out_Ready are both high and Abort is low. Once raised, Out_Valid and
    // the payload hold until that transfer, an Abort, or Reset.

    // The register file reads combinationally from SR1_Sel, so the select is
    // simply the live index; it only has meaning while Busy.
    assign SR1_Sel = idx;
    assign State   = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            Out_Data  <= '0;
            Out_Idx   <= '0;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else if (Abort && state != IDLE) begin
            // Abort beats a same-cycle handshake: the presented word is dropped.
            state     <= IDLE;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= FETCH;
                        idx   <= '0;
                        Busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    Out_Data  <= SR1_In;
                    Out_Idx   <= idx;
                    Out_Valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= FIN;
                            Done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    Out_Valid <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
